// File: rtl/four_bit_comparator.sv
// Registered magnitude comparator with signed/unsigned mode and
// saturating per-outcome event counters.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid            sample x, y, signed_mode on this edge
//   x, y                WIDTH-bit operands
//   signed_mode         0 = unsigned, 1 = two's-complement compare
//   cnt_clr             synchronous clear of the three counters
//   out_valid           one-cycle pulse when g/l/e were just loaded
//   g, l, e             x > y, x < y, x == y (held between compares)
//   gt_cnt/lt_cnt/eq_cnt saturating counts of each outcome
module four_bit_comparator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             g,
    output logic             l,
    output logic             e,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);

    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] x_adj;
    logic [WIDTH-1:0] y_adj;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;

    logic [CNT_W-1:0] gt_cnt_nxt;
    logic [CNT_W-1:0] lt_cnt_nxt;
    logic [CNT_W-1:0] eq_cnt_nxt;

    // Flipping the sign bit maps two's-complement order onto unsigned
    // order, so a single unsigned comparator serves both modes.
    assign x_adj = signed_mode ? (x ^ SIGN_BIT) : x;
    assign y_adj = signed_mode ? (y ^ SIGN_BIT) : y;

    // Equality is bitwise, independent of mode.
    assign cmp_eq = (x == y);
    assign cmp_gt = (x_adj > y_adj);
    assign cmp_lt = ~cmp_eq & ~cmp_gt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Counter next-state: clear beats increment; one outcome bumps.
    always_comb begin
        gt_cnt_nxt = gt_cnt;
        lt_cnt_nxt = lt_cnt;
        eq_cnt_nxt = eq_cnt;
        if (cnt_clr) begin
            gt_cnt_nxt = '0;
            lt_cnt_nxt = '0;
            eq_cnt_nxt = '0;
        end else if (in_valid) begin
            unique case (1'b1)
                cmp_gt:  gt_cnt_nxt = sat_inc(gt_cnt);
                cmp_lt:  lt_cnt_nxt = sat_inc(lt_cnt);
                default: eq_cnt_nxt = sat_inc(eq_cnt);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            g         <= 1'b0;
            l         <= 1'b0;
            e         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Flags hold their last result while idle.
            if (in_valid) begin
                g <= cmp_gt;
                l <= cmp_lt;
                e <= cmp_eq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gt_cnt <= '0;
            lt_cnt <= '0;
            eq_cnt <= '0;
        end else begin
            gt_cnt <= gt_cnt_nxt;
            lt_cnt <= lt_cnt_nxt;
            eq_cnt <= eq_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_four_bit_comparator.sv
// Scoreboard bench for four_bit_comparator (WIDTH=4, CNT_W=2).
// Expected flags are queued at drive time and popped on out_valid.
module tb_four_bit_comparator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] x;
    logic [3:0] y;
    logic       signed_mode;
    logic       cnt_clr;
    logic       out_valid;
    logic       g;
    logic       l;
    logic       e;
    logic [1:0] gt_cnt;
    logic [1:0] lt_cnt;
    logic [1:0] eq_cnt;

    four_bit_comparator #(.WIDTH(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .x          (x),
        .y          (y),
        .signed_mode(signed_mode),
        .cnt_clr    (cnt_clr),
        .out_valid  (out_valid),
        .g          (g),
        .l          (l),
        .e          (e),
        .gt_cnt     (gt_cnt),
        .lt_cnt     (lt_cnt),
        .eq_cnt     (eq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] sb[$];
    logic [2:0] m_flags;
    int         m_gt;
    int         m_lt;
    int         m_eq;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result as {g,l,e}, using native signed arithmetic.
    function automatic logic [2:0] ref_cmp(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic sm);
        int ia;
        int ib;
        if (sm) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        ref_cmp = {ia > ib, ia < ib, ia == ib};
    endfunction

    function automatic int sat(input int c);
        sat = (c >= 3) ? 3 : c + 1;
    endfunction

    task automatic step(input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic sm,
                        input logic clr, input logic rst);
        logic [2:0] r;
        logic [2:0] exp;
        r           = ref_cmp(a, b, sm);
        in_valid    = v;
        x           = a;
        y           = b;
        signed_mode = sm;
        cnt_clr     = clr;
        rst_n       = rst;
        if (rst && v) sb.push_back(r);
        @(posedge clk);
        #1;
        if (!rst) begin
            sb.delete();
            m_flags = 3'b000;
            m_gt = 0;
            m_lt = 0;
            m_eq = 0;
        end else begin
            if (clr) begin
                m_gt = 0;
                m_lt = 0;
                m_eq = 0;
            end else if (v) begin
                if (r[2]) m_gt = sat(m_gt);
                if (r[1]) m_lt = sat(m_lt);
                if (r[0]) m_eq = sat(m_eq);
            end
            if (v) m_flags = r;
        end
        chk("out_valid", 32'(out_valid), 32'(rst && v));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                exp = sb.pop_front();
                chk("sb_flags", 32'({g, l, e}), 32'(exp));
            end
        end
        chk("flags", 32'({g, l, e}), 32'(m_flags));
        chk("gt_cnt", 32'(gt_cnt), 32'(m_gt));
        chk("lt_cnt", 32'(lt_cnt), 32'(m_lt));
        chk("eq_cnt", 32'(eq_cnt), 32'(m_eq));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
    } vec_t;

    vec_t vecs[9] = '{
        '{4'b1000, 4'b1110, 1'b0},
        '{4'b1111, 4'b1111, 1'b0},
        '{4'b1000, 4'b0100, 1'b0},
        '{4'b1100, 4'b1100, 1'b0},
        '{4'b0111, 4'b1111, 1'b0},
        '{4'b0111, 4'b0011, 1'b0},
        '{4'b1000, 4'b0100, 1'b1},
        '{4'b0111, 4'b1111, 1'b1},
        '{4'b1111, 4'b1111, 1'b1}
    };

    initial begin
        m_flags = 3'b000;
        m_gt = 0;
        m_lt = 0;
        m_eq = 0;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        signed_mode = 1'b0;
        cnt_clr = 1'b0;
        rst_n = 1'b0;

        // Reset for two cycles, then idle.
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd5, 4'd2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Unsigned back-to-back.
        for (int i = 0; i < 6; i++)
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("final_gt", 32'(gt_cnt), 32'd2);
        chk("final_lt", 32'(lt_cnt), 32'd2);
        chk("final_eq", 32'(eq_cnt), 32'd2);

        // Signed vectors.
        for (int i = 6; i < 9; i++)
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0, 1'b1);
        chk("signed_last_e", 32'({g, l, e}), 32'(3'b001));

        // Saturation: five equal compares after reset.
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'(i), 4'(i), 1'b0, 1'b0, 1'b1);
        chk("eq_saturated", 32'(eq_cnt), 32'd3);

        // Clear with a simultaneous compare: clear wins, flags update.
        step(1'b1, 4'd9, 4'd3, 1'b0, 1'b1, 1'b1);
        chk("clr_g", 32'(g), 32'd1);

        // Hold: one compare then three idle cycles.
        step(1'b1, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("hold_g", 32'(g), 32'd1);

        // Mid-stream reset.
        step(1'b1, 4'd2, 4'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4'd7, 4'd2, 1'b0, 1'b0, 1'b0);
        chk("midrst_flags", 32'({g, l, e}), 32'(3'b000));

        // Random traffic with occasional clears.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 29) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
